// File: rtl/uart_rx_buffer_pkg.sv
// uart_rx_buffer_pkg: flow-control characters and FSM state type shared by the rx buffer
package uart_rx_buffer_pkg;
  localparam logic [7:0] XON_CHAR = 8'h11;
  localparam logic [7:0] XOFF_CHAR = 8'h13;
  typedef enum logic [1:0] {ON, SEND_XOFF, PAUSED, SEND_XON} FlowCtlState_t;
endpackage

// File: rtl/uart_flow_ctl.sv
// uart_flow_ctl: XON/XOFF request generator driven by the rx buffer fill level
module uart_flow_ctl
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int HIGH_WATER = 48,
  parameter int LOW_WATER = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(DEPTH):0]   level,
  input  logic                     txBusy,
  output logic                     txStart,
  output logic [7:0]               txData,
  output logic                     paused
);
  localparam int LB = $clog2(DEPTH) + 1;
  localparam logic [LB-1:0] HW = LB'(HIGH_WATER);
  localparam logic [LB-1:0] LW = LB'(LOW_WATER);
  FlowCtlState_t state, state_d;
  logic start_d;
  logic [7:0] data_d;
  // state and registered transmit request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ON;
      txStart <= 1'b0;
      txData <= 8'h00;
    end else begin
      state <= state_d;
      txStart <= start_d;
      txData <= data_d;
    end
  end
  // a SEND state always completes its byte, regardless of later level changes
  always_comb begin
    state_d = state;
    start_d = 1'b0;
    data_d = txData;
    case (state)
      ON:        state_d = (level >= HW) ? SEND_XOFF : ON;
      SEND_XOFF: if (!txBusy) begin
        start_d = 1'b1;
        data_d = XOFF_CHAR;
        state_d = PAUSED;
      end
      PAUSED:    state_d = (level <= LW) ? SEND_XON : PAUSED;
      SEND_XON:  if (!txBusy) begin
        start_d = 1'b1;
        data_d = XON_CHAR;
        state_d = ON;
      end
      default:   state_d = ON;
    endcase
  end
  assign paused = (state == PAUSED) || (state == SEND_XON);
endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: show-ahead byte FIFO with sticky overflow; XON/XOFF when UART_RX_BUFFER_FLOWCTL_EN is defined
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int HIGH_WATER = 48,
  parameter int LOW_WATER = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rxValid,
  input  logic [7:0]               rxData,
  output logic                     outValid,
  output logic [7:0]               outData,
  input  logic                     outReady,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clearOverflow,
  output logic                     paused,
  output logic                     txStart,
  output logic [7:0]               txData,
  input  logic                     txBusy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push, pop, drop;
  assign level = wr_ptr - rd_ptr;
  assign outValid = level != '0;
  assign pop = outValid && outReady;
  assign push = rxValid && (level != FULL || pop);
  assign drop = rxValid && !push;
  assign outData = outValid ? mem[rd_ptr[AW-1:0]] : 8'h00;
  // storage, no reset so it maps to distributed RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rxData;
  end
  // pointers and sticky overflow; a drop beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
      overflow <= drop || (overflow && !clearOverflow);
    end
  end
`ifdef UART_RX_BUFFER_FLOWCTL_EN
  uart_flow_ctl #(
    .DEPTH(DEPTH),
    .HIGH_WATER(HIGH_WATER),
    .LOW_WATER(LOW_WATER)
  ) u_flow_ctl (
    .clk(clk),
    .rst(rst),
    .level(level),
    .txBusy(txBusy),
    .txStart(txStart),
    .txData(txData),
    .paused(paused)
  );
`else
  logic unused_tx_busy;
  assign unused_tx_busy = txBusy;
  assign txStart = 1'b0;
  assign txData = 8'h00;
  assign paused = 1'b0;
`endif
endmodule
